// File: rtl/mem_burst_ctrl_pkg.sv
// Shared definitions for the burst memory controller: default geometry and FSM state encoding.
package mcDefs;

    localparam int unsigned BUSWIDTH = 16;
    localparam int unsigned MEMSIZE  = 256;
    localparam int unsigned BURSTLEN = 4;
    localparam int unsigned PAGE_W   = 4;

    typedef enum logic [1:0] {IDLE, READ, WRITE} burst_state_t;

endpackage : mcDefs

// File: rtl/mem_burst_ctrl.sv
// Burst memory controller: decodes a paged bus transaction and sequences a fixed-length
// burst of reads or writes into one memory array.
module mem_burst_ctrl #(
    parameter int unsigned                   BUSWIDTH = mcDefs::BUSWIDTH,
    parameter int unsigned                   MEMSIZE  = mcDefs::MEMSIZE,
    parameter logic [mcDefs::PAGE_W-1:0]     PAGEID   = 4'h0,
    parameter int unsigned                   BURSTLEN = mcDefs::BURSTLEN
) (
    input  logic                             clk,
    input  logic                             resetH,
    input  logic                             AddrValid,
    input  logic                             rw,
    input  logic [BUSWIDTH-1:0]              BusDataIn,
    output logic [BUSWIDTH-1:0]              BusDataOut,
    output logic                             BusDataOE,
    output logic                             Busy,
    output logic [$clog2(MEMSIZE)-1:0]       Addr,
    output logic                             rdEn,
    output logic                             wrEn,
    output logic [BUSWIDTH-1:0]              MemDataIn,
    input  logic [BUSWIDTH-1:0]              MemDataOut
);
    import mcDefs::*;

    localparam int unsigned ADDRWIDTH = $clog2(MEMSIZE);
    localparam int unsigned BEATW     = $clog2(BURSTLEN) + 1;

    burst_state_t           state_q, state_d;
    logic [BEATW-1:0]       beat_q,  beat_d;
    logic [ADDRWIDTH-1:0]   base_q,  base_d;

    logic                   page_hit_c;
    logic                   accept_c;
    logic                   last_beat_c;
    logic [ADDRWIDTH-1:0]   addr_c;

    assign page_hit_c  = (BusDataIn[BUSWIDTH-1 -: PAGE_W] == PAGEID);
    assign accept_c    = AddrValid && page_hit_c && (state_q == IDLE);
    assign last_beat_c = (beat_q == BEATW'(BURSTLEN - 1));
    // Address arithmetic is ADDRWIDTH bits wide so bursts wrap at the end of the array.
    assign addr_c      = base_q + ADDRWIDTH'(beat_q);

    // State, beat counter and base address register with synchronous reset.
    always_ff @(posedge clk) begin
        if (resetH) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = rw ? READ : WRITE;
                    beat_d  = '0;
                    base_d  = BusDataIn[ADDRWIDTH-1:0];
                end
            end
            READ, WRITE: begin
                beat_d = beat_q + BEATW'(1);
                if (last_beat_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-state outputs; everything is held low while reset is asserted so no write lands on the reset edge.
    always_comb begin
        rdEn       = 1'b0;
        wrEn       = 1'b0;
        BusDataOE  = 1'b0;
        Busy       = 1'b0;
        Addr       = '0;
        BusDataOut = '0;
        MemDataIn  = '0;
        if (!resetH) begin
            unique case (state_q)
                READ: begin
                    rdEn       = 1'b1;
                    Busy       = 1'b1;
                    BusDataOE  = 1'b1;
                    Addr       = addr_c;
                    BusDataOut = MemDataOut;
                end
                WRITE: begin
                    wrEn      = 1'b1;
                    Busy      = 1'b1;
                    Addr      = addr_c;
                    MemDataIn = BusDataIn;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : mem_burst_ctrl

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl with a behavioural memory array attached.
module tb_mem_burst_ctrl;

    logic        clk;
    logic        resetH;
    logic        AddrValid;
    logic        rw;
    logic [15:0] BusDataIn;
    logic [15:0] BusDataOut;
    logic        BusDataOE;
    logic        Busy;
    logic [7:0]  Addr;
    logic        rdEn;
    logic        wrEn;
    logic [15:0] MemDataIn;
    logic [15:0] MemDataOut;

    logic [15:0] mem [256];
    int          wr_cnt;
    int          errors;
    int          checks;

    mem_burst_ctrl #(
        .BUSWIDTH (16),
        .MEMSIZE  (256),
        .PAGEID   (4'h0),
        .BURSTLEN (4)
    ) dut (
        .clk        (clk),
        .resetH     (resetH),
        .AddrValid  (AddrValid),
        .rw         (rw),
        .BusDataIn  (BusDataIn),
        .BusDataOut (BusDataOut),
        .BusDataOE  (BusDataOE),
        .Busy       (Busy),
        .Addr       (Addr),
        .rdEn       (rdEn),
        .wrEn       (wrEn),
        .MemDataIn  (MemDataIn),
        .MemDataOut (MemDataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: synchronous write, combinational read.
    always @(posedge clk) begin
        if (wrEn) begin
            mem[Addr] <= MemDataIn;
            wr_cnt    <= wr_cnt + 1;
        end
    end
    assign MemDataOut = rdEn ? mem[Addr] : 16'h0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"},  32'(Busy),      32'h0);
        check({tag, " wren"},  32'(wrEn),      32'h0);
        check({tag, " rden"},  32'(rdEn),      32'h0);
        check({tag, " oe"},    32'(BusDataOE), 32'h0);
        check({tag, " addr"},  32'(Addr),      32'h0);
        check({tag, " bdo"},   32'(BusDataOut), 32'h0);
        check({tag, " mdi"},   32'(MemDataIn), 32'h0);
    endtask

    // Drive one cycle of inputs after the falling edge, then let combinational outputs settle.
    task automatic drive(input logic av, input logic r, input logic [15:0] d);
        @(negedge clk);
        AddrValid = av;
        rw        = r;
        BusDataIn = d;
        #1;
    endtask

    task automatic write_burst(input string tag, input logic [7:0] base, input logic [15:0] d0,
                               input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3);
        logic [15:0] wd [4];
        wd[0] = d0; wd[1] = d1; wd[2] = d2; wd[3] = d3;
        drive(1'b1, 1'b0, {8'h00, base});
        check({tag, " pre busy"}, 32'(Busy), 32'h0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, wd[k]);
            check($sformatf("%s wren b%0d", tag, k), 32'(wrEn), 32'h1);
            check($sformatf("%s busy b%0d", tag, k), 32'(Busy), 32'h1);
            check($sformatf("%s addr b%0d", tag, k), 32'(Addr), 32'(8'(base + 8'(k))));
            check($sformatf("%s mdi b%0d", tag, k), 32'(MemDataIn), 32'(wd[k]));
        end
        drive(1'b0, 1'b0, 16'h0000);
        check_idle({tag, " post"});
    endtask

    task automatic read_burst(input string tag, input logic [7:0] base, input logic [15:0] d0,
                              input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3);
        logic [15:0] rd [4];
        rd[0] = d0; rd[1] = d1; rd[2] = d2; rd[3] = d3;
        drive(1'b1, 1'b1, {8'h00, base});
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 16'h0000);
            check($sformatf("%s oe b%0d", tag, k),   32'(BusDataOE), 32'h1);
            check($sformatf("%s rden b%0d", tag, k), 32'(rdEn), 32'h1);
            check($sformatf("%s wren b%0d", tag, k), 32'(wrEn), 32'h0);
            check($sformatf("%s addr b%0d", tag, k), 32'(Addr), 32'(8'(base + 8'(k))));
            check($sformatf("%s bdo b%0d", tag, k),  32'(BusDataOut), 32'(rd[k]));
        end
        drive(1'b0, 1'b0, 16'h0000);
        check_idle({tag, " post"});
    endtask

    initial begin
        int wr_base;
        errors    = 0;
        checks    = 0;
        wr_cnt    = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        resetH    = 1'b1;
        AddrValid = 1'b0;
        rw        = 1'b0;
        BusDataIn = 16'h0000;

        // Reset: outputs low, even with a valid-looking address on the bus.
        drive(1'b1, 1'b0, 16'h0010);
        check_idle("rst");
        drive(1'b0, 1'b0, 16'h0000);
        check_idle("rst2");
        @(negedge clk);
        resetH = 1'b0;
        #1;
        check_idle("rst_rel");

        // Write burst then read it back.
        wr_base = wr_cnt;
        write_burst("wr", 8'h10, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        check("wr count", 32'(wr_cnt - wr_base), 32'd4);
        check("mem10", 32'(mem[8'h10]), 32'h1111);
        check("mem11", 32'(mem[8'h11]), 32'h2222);
        check("mem12", 32'(mem[8'h12]), 32'h3333);
        check("mem13", 32'(mem[8'h13]), 32'h4444);
        read_burst("rd", 8'h10, 16'h1111, 16'h2222, 16'h3333, 16'h4444);

        // Wrap across the top of the array.
        write_burst("wrap", 8'hFE, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
        check("memFE", 32'(mem[8'hFE]), 32'hAAAA);
        check("mem01", 32'(mem[8'h01]), 32'hDDDD);
        read_burst("wraprd", 8'hFE, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);

        // Page mismatch is ignored.
        wr_base = wr_cnt;
        drive(1'b1, 1'b0, 16'h1020);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 16'h5555);
            check_idle($sformatf("page c%0d", k));
        end
        check("page mem20", 32'(mem[8'h20]), 32'h0);
        check("page wr count", 32'(wr_cnt - wr_base), 32'd0);

        // Overlapping AddrValid at T+2 is ignored; its page-0 word is just beat-1 data.
        wr_base = wr_cnt;
        drive(1'b1, 1'b0, 16'h0030);
        drive(1'b0, 1'b0, 16'h0101);
        drive(1'b1, 1'b1, 16'h0040);
        check("ovl addr b1", 32'(Addr), 32'h31);
        drive(1'b0, 1'b0, 16'h0303);
        check("ovl wren b2", 32'(wrEn), 32'h1);
        drive(1'b0, 1'b0, 16'h0404);
        check("ovl addr b3", 32'(Addr), 32'h33);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 16'h0000);
            check_idle($sformatf("ovl post c%0d", k));
        end
        check("ovl wr count", 32'(wr_cnt - wr_base), 32'd4);
        check("ovl mem31", 32'(mem[8'h31]), 32'h0040);
        check("ovl mem33", 32'(mem[8'h33]), 32'h0404);
        check("ovl mem40", 32'(mem[8'h40]), 32'h0);

        // Reset during beat 2: beats 0 and 1 land, beat 2 does not.
        wr_base = wr_cnt;
        drive(1'b1, 1'b0, 16'h0050);
        drive(1'b0, 1'b0, 16'hE000);
        drive(1'b0, 1'b0, 16'hE001);
        @(negedge clk);
        resetH    = 1'b1;
        BusDataIn = 16'hE002;
        #1;
        check_idle("mrst during");
        drive(1'b0, 1'b0, 16'hE003);
        check_idle("mrst during2");
        @(negedge clk);
        resetH = 1'b0;
        #1;
        check_idle("mrst after");
        drive(1'b0, 1'b0, 16'h0000);
        check_idle("mrst after2");
        check("mrst wr count", 32'(wr_cnt - wr_base), 32'd2);
        check("mrst mem50", 32'(mem[8'h50]), 32'hE000);
        check("mrst mem51", 32'(mem[8'h51]), 32'hE001);
        check("mrst mem52", 32'(mem[8'h52]), 32'h0);
        check("mrst mem53", 32'(mem[8'h53]), 32'h0);

        // Normal operation after reset recovery.
        write_burst("rec", 8'h60, 16'h6000, 16'h6001, 16'h6002, 16'h6003);
        read_burst("recrd", 8'h60, 16'h6000, 16'h6001, 16'h6002, 16'h6003);
        read_burst("rd2", 8'h10, 16'h1111, 16'h2222, 16'h3333, 16'h4444);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_burst_ctrl
